// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 4-digit seven-segment scanner.
package display_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam logic [6:0]  SEG_OFF = 7'b1111111;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // A digit above digit 0 is a leading zero when it and every higher nibble are zero.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] idx);
    return (idx != 2'd0) && ((v >> (4 * idx)) == 16'h0000);
  endfunction

endpackage

// File: rtl/coder.sv
// Hex nibble to active-low seven-segment pattern, segment a on bit 0.
module coder
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (nib_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scanner for a 4-digit common-anode display with
// double-buffered value loading synchronised to frame boundaries.
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned GAP      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > GAP) ? SCAN_DIV : GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam int unsigned IW      = $clog2(DIGITS);

  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  scan_state_e   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [15:0]   disp_val_q, disp_val_d;
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_q, pend_d;

  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;

  logic [3:0]    sel_nib;
  logic [6:0]    dec_seg;
  logic          lz_off;

  // Slot sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      BLANK: begin
        if (cnt_q == GAP_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Loads land in the pending buffer; the visible copy only changes at frame end,
  // with a load on that very cycle taking priority over the pending contents.
  always_comb begin
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;
    if (fd_q) begin
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pend_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      pend_d     = 1'b1;
    end
  end

  assign sel_nib = disp_val_q[4 * idx_d +: 4];
  assign lz_off  = blank_lz && lz_blank(disp_val_q, idx_d);

  coder u_coder (
    .nib_i (sel_nib),
    .seg_o (dec_seg)
  );

  // Outputs are computed from the next state so they register on the same edge
  // as the state change; digit content (and blank_lz) is latched at slot entry.
  always_comb begin
    seg_d = seg_q;
    dp_d  = dp_q;
    an_d  = an_q;
    if (state_d == BLANK) begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      an_d  = '1;
    end else if (state_q == BLANK) begin
      if (lz_off) begin
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        an_d  = '1;
      end else begin
        seg_d = dec_seg;
        dp_d  = ~disp_dp_q[idx_d];
        an_d  = ~(4'b0001 << idx_d);
      end
    end
    fd_d = (state_d == SHOW) && (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BLANK;
      idx_q      <= '0;
      cnt_q      <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: per-cycle expected outputs are queued per frame.
module tb_display_scan;

  localparam int SD    = 4;
  localparam int GP    = 2;
  localparam int FRAME = 4 * (SD + GP);

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  logic [6:0] hex7 [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  display_scan #(.SCAN_DIV(SD), .GAP(GP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Queue one frame of expected outputs, starting at the first gap cycle.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic blz);
    exp_t e;
    logic off;
    logic [15:0] hi;
    for (int k = 0; k < 4; k++) begin
      hi  = v >> (4 * k);
      off = blz && (k > 0) && (hi == 16'h0000);
      for (int c = 0; c < GP; c++) q.push_back('{4'hF, 7'h7F, 1'b1, 1'b0});
      for (int c = 0; c < SD; c++) begin
        if (off) begin
          e = '{4'hF, 7'h7F, 1'b1, 1'b0};
        end else begin
          e.an    = 4'hF;
          e.an[k] = 1'b0;
          e.seg   = hex7[hi[3:0]];
          e.dp    = ~d[k];
          e.fd    = 1'b0;
        end
        e.fd = (k == 3) && (c == SD - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold got an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame(16'h0000, 4'h0, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== e) begin
        bad++;
        $display("FAIL reset_frame[%0d] got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
    end
  endtask

  task automatic test_decode();
    exp_t e;
    bit ok;
    @(negedge clk);
    value = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fd(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL decode_fd_wait got=timeout want=frame_done");
    end
    push_frame(16'h12AF, 4'b0100, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== e) begin
        bad++;
        $display("FAIL decode[%0d] got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
    end
  endtask

  task automatic test_load_timing();
    exp_t e;
    // Two loads mid-frame: old value held, last load wins at frame end.
    push_frame(16'h12AF, 4'b0100, 1'b0);
    push_frame(16'h2222, 4'b0001, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== e) begin
        bad++;
        $display("FAIL load_midframe[%0d] got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
      if (i == 3)  begin value = 16'h1111; dp_in = 4'b0000; load = 1'b1; end
      if (i == 4)  load = 1'b0;
      if (i == 10) begin value = 16'h2222; dp_in = 4'b0001; load = 1'b1; end
      if (i == 11) load = 1'b0;
    end
    // Load on the frame_done cycle goes straight to the display; nothing left pending.
    value = 16'h3C5D; dp_in = 4'b1010; load = 1'b1;
    push_frame(16'h3C5D, 4'b1010, 1'b0);
    push_frame(16'h3C5D, 4'b1010, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== e) begin
        bad++;
        $display("FAIL load_on_fd[%0d] got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
      if (i == 0) load = 1'b0;
    end
  endtask

  task automatic test_blank_lz();
    exp_t e;
    blank_lz = 1'b1;
    value = 16'h0040; dp_in = 4'b1100; load = 1'b1;
    push_frame(16'h0040, 4'b1100, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== e) begin
        bad++;
        $display("FAIL blank_0040[%0d] got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
      if (i == 0) load = 1'b0;
    end
    value = 16'h0000; dp_in = 4'b0000; load = 1'b1;
    push_frame(16'h0000, 4'b0000, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== e) begin
        bad++;
        $display("FAIL blank_0000[%0d] got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
      if (i == 0) load = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    blank_lz = 1'b0;
    push_frame(16'h0000, 4'b0000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== e) begin
        bad++;
        $display("FAIL pre_reset[%0d] got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
      if (i == 4) begin value = 16'h9876; dp_in = 4'b1111; load = 1'b1; end
      if (i == 5) load = 1'b0;
    end
    // Now inside the digit-2 slot with a load pending.
    q.delete();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_async got an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame(16'h0000, 4'b0000, 1'b0);
    push_frame(16'h0000, 4'b0000, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if ({an, seg, dp, frame_done} !== e) begin
        bad++;
        $display("FAIL post_reset[%0d] got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_timing();
    test_blank_lz();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
